// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
//   clog2        : ceiling log2, used to size storage index and pointers
//   addr_w/ptr_w : storage index width (AW) and pointer width (AW+1)
//   FIFO_SHOWAHEAD / FIFO_REGOUT : values of the out_reg read-mode parameter
package fifo_pkg;

  localparam int FIFO_SHOWAHEAD = 0;
  localparam int FIFO_REGOUT    = 1;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Index width into storage.
  function automatic int addr_w(input int depth);
    return clog2(depth);
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_mux.sv
// depth:1 read multiplexer selecting the FIFO head entry.
//   data_i : all storage entries, W = simd*bw bits each
//   sel    : storage index of the head (low AW bits of the read pointer)
//   dout   : selected entry
module fifo_rd_mux
  import fifo_pkg::*;
#(
  parameter  int bw    = 4,
  parameter  int simd  = 1,
  parameter  int depth = 64,
  localparam int W     = simd * bw,
  localparam int AW    = addr_w(depth)
) (
  input  logic [W-1:0]  data_i [depth],
  input  logic [AW-1:0] sel,
  output logic [W-1:0]  dout
);

  assign dout = data_i[sel];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO staging activation/weight/psum vectors.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   in, wr     : write data and write request
//   rd         : read request (pop)
//   flush      : synchronous empty; storage, out and sticky errors are kept
//   out        : head data (show-ahead) or last popped data (registered mode)
//   o_full, o_empty, o_afull, o_aempty, o_count : occupancy status
//   o_ovf, o_unf : sticky overflow / underflow, cleared only by reset
//
// Handshake: wr and rd are plain requests with no back-pressure signal in
// the other direction. A write is accepted when the FIFO is not full or a
// read is accepted on the same edge; a read is accepted when not empty.
// Requests that cannot be accepted are dropped and recorded in o_ovf/o_unf.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter  int bw        = 4,
  parameter  int simd      = 1,
  parameter  int depth     = 64,
  parameter  int afull_th  = 60,
  parameter  int aempty_th = 4,
  parameter  int out_reg   = FIFO_SHOWAHEAD,
  localparam int W         = simd * bw,
  localparam int AW        = addr_w(depth)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  in,
  input  logic          wr,
  input  logic          rd,
  input  logic          flush,
  output logic [W-1:0]  out,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_afull,
  output logic          o_aempty,
  output logic [AW:0]   o_count,
  output logic          o_ovf,
  output logic          o_unf
);

  localparam int PW = ptr_w(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AFULL_C  = CW'(afull_th);
  localparam logic [CW-1:0] AEMPTY_C = CW'(aempty_th);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  mem_q [depth];
  logic [W-1:0]  mem_d [depth];
  logic [W-1:0]  out_q, out_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic [W-1:0]  head;
  logic          full, empty, wr_ok, rd_ok;

  // Same storage slot with different wrap bits means a whole lap apart.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A pop on the same edge frees the slot, so a write into a full FIFO
  // is still accepted when it is paired with a read.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  fifo_rd_mux #(
    .bw    (bw),
    .simd  (simd),
    .depth (depth)
  ) u_rd_mux (
    .data_i (mem_q),
    .sel    (rd_ptr_q[AW-1:0]),
    .dout   (head)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) begin
        mem_d[wr_ptr_q[AW-1:0]] = in;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        out_d    = head;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (wr && !wr_ok) ovf_d = 1'b1;
      if (rd && empty)  unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
      out_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign out      = (out_reg == FIFO_REGOUT) ? out_q : head;
  assign o_full   = full;
  assign o_empty  = empty;
  assign o_count  = count_q;
  assign o_afull  = (count_q >= AFULL_C);
  assign o_aempty = (count_q <= AEMPTY_C);
  assign o_ovf    = ovf_q;
  assign o_unf    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: two instances (show-ahead and registered
// output) share one stimulus stream; a queue-based model is compared
// against both on every falling edge, and directed steps pin literals.
module tb_fifo_sync_param;

  localparam int DEPTH = 8;
  localparam int BW    = 8;
  localparam int AFT   = 6;
  localparam int AET   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [BW-1:0] din = '0;
  logic wr = 1'b0, rd = 1'b0, flush = 1'b0;

  logic [BW-1:0] out0, out1;
  logic full0, empty0, afull0, aempty0, ovf0, unf0;
  logic full1, empty1, afull1, aempty1, ovf1, unf1;
  logic [3:0] count0, count1;

  fifo_sync_param #(.bw(BW), .simd(1), .depth(DEPTH), .afull_th(AFT),
                    .aempty_th(AET), .out_reg(0)) dut0 (
    .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd), .flush(flush),
    .out(out0), .o_full(full0), .o_empty(empty0), .o_afull(afull0),
    .o_aempty(aempty0), .o_count(count0), .o_ovf(ovf0), .o_unf(unf0));

  fifo_sync_param #(.bw(BW), .simd(1), .depth(DEPTH), .afull_th(AFT),
                    .aempty_th(AET), .out_reg(1)) dut1 (
    .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd), .flush(flush),
    .out(out1), .o_full(full1), .o_empty(empty1), .o_afull(afull1),
    .o_aempty(aempty1), .o_count(count1), .o_ovf(ovf1), .o_unf(unf1));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: contents as a queue, popped data for registered mode.
  logic [BW-1:0] exp_q[$];
  bit            m_ovf = 0, m_unf = 0, model_ok = 0;
  logic [BW-1:0] m_out1 = '0;
  bit            m_r, m_w;

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_ovf = 0;
      m_unf = 0;
      m_out1 = '0;
      model_ok = 1;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      m_r = rd && (exp_q.size() != 0);
      m_w = wr && ((exp_q.size() != DEPTH) || m_r);
      if (rd && exp_q.size() == 0) m_unf = 1;
      if (wr && !m_w) m_ovf = 1;
      if (m_r) m_out1 = exp_q.pop_front();
      if (m_w) exp_q.push_back(din);
    end
  end

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      check("count0", 32'(count0), 32'(exp_q.size()));
      check("count1", 32'(count1), 32'(exp_q.size()));
      check("empty0", 32'(empty0), 32'(exp_q.size() == 0));
      check("full0", 32'(full0), 32'(exp_q.size() == DEPTH));
      check("full1", 32'(full1), 32'(exp_q.size() == DEPTH));
      check("afull0", 32'(afull0), 32'(exp_q.size() >= AFT));
      check("aempty0", 32'(aempty0), 32'(exp_q.size() <= AET));
      check("empty1", 32'(empty1), 32'(exp_q.size() == 0));
      check("afull1", 32'(afull1), 32'(exp_q.size() >= AFT));
      check("aempty1", 32'(aempty1), 32'(exp_q.size() <= AET));
      check("ovf0", 32'(ovf0), 32'(m_ovf));
      check("unf0", 32'(unf0), 32'(m_unf));
      check("ovf1", 32'(ovf1), 32'(m_ovf));
      check("unf1", 32'(unf1), 32'(m_unf));
      if (exp_q.size() != 0) check("head0", 32'(out0), 32'(exp_q[0]));
      check("regout1", 32'(out1), 32'(m_out1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic w, input logic r, input logic f,
                      input logic [BW-1:0] d);
    wr = w; rd = r; flush = f; din = d;
    @(posedge clk); #1;
    wr = 0; rd = 0; flush = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    reset = 0;
  endtask

  task automatic fill_1_to_8();
    for (int i = 1; i <= DEPTH; i++) step(1, 0, 0, 8'(i));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int wcount, rcount;
    do_reset();
    check("rst_count", 32'(count0), 0);
    check("rst_empty", 32'(empty0), 1);
    check("rst_full", 32'(full0), 0);
    check("rst_afull", 32'(afull0), 0);
    check("rst_aempty", 32'(aempty0), 1);
    check("rst_ovf", 32'(ovf0), 0);
    check("rst_unf", 32'(unf0), 0);
    check("rst_out0", 32'(out0), 0);
    check("rst_out1", 32'(out1), 0);

    // 1: fill and drain, watching the threshold flags
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0, 0, 8'(i));
      check("t1_count", 32'(count0), 32'(i));
      check("t1_aempty", 32'(aempty0), 32'(i <= 2));
      check("t1_afull", 32'(afull0), 32'(i >= 6));
    end
    check("t1_full", 32'(full0), 1);
    for (int i = 1; i <= DEPTH; i++) begin
      check("t1_rd", 32'(out0), 32'(i));
      step(0, 1, 0, 8'h00);
    end
    check("t1_empty", 32'(empty0), 1);

    // 2: write while full is dropped
    fill_1_to_8();
    step(1, 0, 0, 8'h99);
    check("t2_ovf", 32'(ovf0), 1);
    check("t2_count", 32'(count0), 8);
    for (int i = 1; i <= DEPTH; i++) begin
      check("t2_rd", 32'(out0), 32'(i));
      step(0, 1, 0, 8'h00);
    end

    // 3: underflow, then simultaneous wr/rd while empty
    step(0, 1, 0, 8'h00);
    check("t3_unf", 32'(unf0), 1);
    step(1, 1, 0, 8'h55);
    check("t3_count", 32'(count0), 1);
    check("t3_out", 32'(out0), 32'h55);
    step(0, 1, 0, 8'h00);

    // 4: simultaneous wr/rd while full
    do_reset();
    check("t4_ovf_rst", 32'(ovf0), 0);
    fill_1_to_8();
    for (int k = 0; k < DEPTH; k++) begin
      check("t4_head", 32'(out0), 32'(k + 1));
      step(1, 1, 0, 8'(8'hA0 + k));
      check("t4_count", 32'(count0), 8);
      check("t4_ovf", 32'(ovf0), 0);
    end
    check("t4_newhead", 32'(out0), 32'hA0);
    for (int k = 0; k < DEPTH; k++) begin
      check("t4_drain", 32'(out0), 32'(8'hA0 + k));
      step(0, 1, 0, 8'h00);
    end

    // 5: interleaved traffic across wraps, then flush and reset
    step(0, 1, 0, 8'h00);
    wcount = 0;
    rcount = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 8'(8'h30 + wcount));
      wcount++;
    end
    for (int j = 0; j < 17; j++) begin
      step(1, 0, 0, 8'(8'h30 + wcount));
      wcount++;
      check("t5_count_hi", 32'(count0), 4);
      check("t5_order", 32'(out0), 32'(8'h30 + rcount));
      step(0, 1, 0, 8'h00);
      rcount++;
      check("t5_count_lo", 32'(count0), 3);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 8'(8'h30 + wcount));
      wcount++;
    end
    step(1, 0, 0, 8'hEE);
    check("t5_ovf", 32'(ovf0), 1);
    check("t5_unf", 32'(unf0), 1);
    step(1, 1, 1, 8'h77);
    check("t5_fl_count", 32'(count0), 0);
    check("t5_fl_empty", 32'(empty0), 1);
    check("t5_fl_ovf", 32'(ovf0), 1);
    check("t5_fl_unf", 32'(unf0), 1);
    check("t5_fl_out1", 32'(out1), 32'h40);
    do_reset();
    check("t5_rst_ovf", 32'(ovf0), 0);
    check("t5_rst_unf", 32'(unf0), 0);

    // 6: registered-output timing
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    check("t6_pre", 32'(out1), 0);
    step(0, 1, 0, 8'h00);
    check("t6_rd1", 32'(out1), 32'h11);
    step(0, 0, 0, 8'h00);
    check("t6_hold1", 32'(out1), 32'h11);
    step(0, 1, 0, 8'h00);
    check("t6_rd2", 32'(out1), 32'h22);
    step(0, 0, 0, 8'h00);
    check("t6_hold2", 32'(out1), 32'h22);
    check("t6_empty", 32'(empty1), 1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
